// File: rtl/coh_pkg.sv
// Coherence definitions shared by the snooping cache controllers and the data-bus selector.
// Holds line states, bus commands, bus-word field positions and a bus-word packing helper.
package coh_pkg;

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_RDX  = 2'b10;
    localparam logic [1:0] CMD_WB   = 2'b11;

    localparam int WORD_W  = 12;
    localparam int WB_BIT  = 11;
    localparam int SUP_BIT = 10;
    localparam int ST_HI   = 9;
    localparam int ST_LO   = 8;
    localparam int ADDR_HI = 7;
    localparam int ADDR_LO = 4;
    localparam int DATA_HI = 3;
    localparam int DATA_LO = 0;

    typedef struct packed {
        logic [1:0] state;
        logic [3:0] addr;
        logic [3:0] data;
    } line_t;

    function automatic logic [WORD_W-1:0] bus_word(input logic wb, input logic sup, input line_t line);
        logic [WORD_W-1:0] w;
        w                   = '0;
        w[WB_BIT]           = wb;
        w[SUP_BIT]          = sup;
        w[ST_HI:ST_LO]      = line.state;
        w[ADDR_HI:ADDR_LO]  = line.addr;
        w[DATA_HI:DATA_LO]  = line.data;
        return w;
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Direct-mapped line storage: CPU-side lookup, single write port and the snoop-update path.
// The lookup result already reflects a snoop hitting the same line in the same cycle.
module cache_line_array
    import coh_pkg::*;
#(
    parameter int  PROC_ID   = 0,
    parameter int  NUM_LINES = 4,
    localparam int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] lk_idx,
    output line_t            lk_line,
    input  logic             snp_valid,
    input  logic [1:0]       snp_cmd,
    input  logic [3:0]       snp_addr,
    input  logic [1:0]       snp_owner,
    output logic             snp_hit,
    output line_t            snp_line,
    input  logic             wr_en,
    input  line_t            wr_line
);

    localparam logic [1:0] MY_ID = 2'(PROC_ID);

    logic [1:0]       state_q [NUM_LINES];
    logic [1:0]       state_d [NUM_LINES];
    logic [3:0]       addr_q  [NUM_LINES];
    logic [3:0]       addr_d  [NUM_LINES];
    logic [3:0]       data_q  [NUM_LINES];
    logic [3:0]       data_d  [NUM_LINES];
    logic [IDX_W-1:0] snp_idx;
    logic [1:0]       snp_state_post;

    assign snp_idx = snp_addr[IDX_W-1:0];

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        snp_line = {state_q[snp_idx], addr_q[snp_idx], data_q[snp_idx]};
        snp_hit  = snp_valid && (snp_owner != MY_ID)
                && ((snp_cmd == CMD_RD) || (snp_cmd == CMD_RDX))
                && (snp_line.state != ST_I) && (snp_line.addr == snp_addr);
        snp_state_post = (snp_cmd == CMD_RDX) ? ST_I : ST_S;

        lk_line = {state_q[lk_idx], addr_q[lk_idx], data_q[lk_idx]};
        if (snp_hit && (snp_idx == lk_idx)) begin
            lk_line.state = snp_state_post;
        end

        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (snp_hit) begin
            state_d[snp_idx] = snp_state_post;
        end
        // Controller writes (fill, writeback invalidate) override a same-cycle snoop update.
        if (wr_en) begin
            state_d[lk_idx] = wr_line.state;
            addr_d[lk_idx]  = wr_line.addr;
            data_d[lk_idx]  = wr_line.data;
        end
    end

    // NOTE: only the line states are reset; tag and data contents are don't-care while a line is I.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                state_q[i] <= ST_I;
            end
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/snoop_cache_ctrl.sv
// Per-core snooping MSI cache controller: CPU handshake, miss/writeback FSM and snoop supply.
// Every output is a registered copy of a _q flop.
module snoop_cache_ctrl
    import coh_pkg::*;
#(
    parameter int PROC_ID   = 0,
    parameter int NUM_LINES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_addr,
    input  logic [3:0]        cpu_wdata,
    output logic              cpu_ready,
    output logic [3:0]        cpu_rdata,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic [1:0]        bus_cmd,
    output logic [3:0]        bus_addr,
    input  logic              snp_valid,
    input  logic [1:0]        snp_cmd,
    input  logic [3:0]        snp_addr,
    input  logic [1:0]        snp_owner,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] supply_word
);

    localparam int IDX_W = $clog2(NUM_LINES);

    typedef enum logic [2:0] {IDLE, WB_REQ, WB_ISSUE, REQ, ISSUE, RESP} fsm_e;

    fsm_e              state_q, state_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic [3:0]        cpu_rdata_q, cpu_rdata_d;
    logic              bus_req_q, bus_req_d;
    logic [1:0]        bus_cmd_q, bus_cmd_d;
    logic [3:0]        bus_addr_q, bus_addr_d;
    logic [WORD_W-1:0] supply_word_q, supply_word_d;

    line_t lk_line;
    line_t snp_line;
    line_t wr_line;
    line_t wb_line;
    logic  snp_hit;
    logic  wr_en;
    logic  hit;
    logic  unused_data_in;

    assign unused_data_in = ^data_in[WORD_W-1:DATA_HI+1];
    assign wb_line        = '{state: ST_M, addr: lk_line.addr, data: lk_line.data};

    cache_line_array #(
        .PROC_ID   (PROC_ID),
        .NUM_LINES (NUM_LINES)
    ) u_lines (
        .clk       (clk),
        .rst       (rst),
        .lk_idx    (cpu_addr[IDX_W-1:0]),
        .lk_line   (lk_line),
        .snp_valid (snp_valid),
        .snp_cmd   (snp_cmd),
        .snp_addr  (snp_addr),
        .snp_owner (snp_owner),
        .snp_hit   (snp_hit),
        .snp_line  (snp_line),
        .wr_en     (wr_en),
        .wr_line   (wr_line)
    );

    always_comb begin
        state_d       = state_q;
        cpu_ready_d   = 1'b0;
        cpu_rdata_d   = '0;
        bus_req_d     = bus_req_q;
        bus_cmd_d     = CMD_NONE;
        bus_addr_d    = '0;
        supply_word_d = snp_hit ? bus_word(1'b0, 1'b1, snp_line) : '0;
        wr_en         = 1'b0;
        wr_line       = lk_line;
        hit           = (lk_line.state != ST_I) && (lk_line.addr == cpu_addr);

        case (state_q)
            IDLE: begin
                // While cpu_ready is showing, the still-held request is the one just completed.
                if (cpu_req && !cpu_ready_q) begin
                    if (hit && (!cpu_we || (lk_line.state == ST_M))) begin
                        cpu_ready_d = 1'b1;
                        if (cpu_we) begin
                            wr_en        = 1'b1;
                            wr_line.data = cpu_wdata;
                            cpu_rdata_d  = cpu_wdata;
                        end else begin
                            cpu_rdata_d  = lk_line.data;
                        end
                    end else begin
                        bus_req_d = 1'b1;
                        state_d   = ((lk_line.state == ST_M) && (lk_line.addr != cpu_addr)) ? WB_REQ : REQ;
                    end
                end
            end
            WB_REQ: begin
                if (bus_grant) begin
                    state_d       = WB_ISSUE;
                    bus_req_d     = 1'b0;
                    bus_cmd_d     = CMD_WB;
                    bus_addr_d    = lk_line.addr;
                    supply_word_d = bus_word(1'b1, 1'b0, wb_line);
                end
            end
            WB_ISSUE: begin
                wr_en         = 1'b1;
                wr_line.state = ST_I;
                bus_req_d     = 1'b1;
                state_d       = REQ;
            end
            REQ: begin
                if (bus_grant) begin
                    state_d    = ISSUE;
                    bus_req_d  = 1'b0;
                    bus_cmd_d  = cpu_we ? CMD_RDX : CMD_RD;
                    bus_addr_d = cpu_addr;
                end
            end
            ISSUE: begin
                state_d = RESP;
            end
            RESP: begin
                wr_en         = 1'b1;
                wr_line.state = cpu_we ? ST_M : ST_S;
                wr_line.addr  = cpu_addr;
                wr_line.data  = cpu_we ? cpu_wdata : data_in[DATA_HI:DATA_LO];
                cpu_ready_d   = 1'b1;
                cpu_rdata_d   = wr_line.data;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cpu_ready_q   <= 1'b0;
            cpu_rdata_q   <= '0;
            bus_req_q     <= 1'b0;
            bus_cmd_q     <= CMD_NONE;
            bus_addr_q    <= '0;
            supply_word_q <= '0;
        end else begin
            state_q       <= state_d;
            cpu_ready_q   <= cpu_ready_d;
            cpu_rdata_q   <= cpu_rdata_d;
            bus_req_q     <= bus_req_d;
            bus_cmd_q     <= bus_cmd_d;
            bus_addr_q    <= bus_addr_d;
            supply_word_q <= supply_word_d;
        end
    end

    assign cpu_ready   = cpu_ready_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign bus_req     = bus_req_q;
    assign bus_cmd     = bus_cmd_q;
    assign bus_addr    = bus_addr_q;
    assign supply_word = supply_word_q;

endmodule

// File: tb/tb_snoop_cache_ctrl.sv
// Directed bench for snoop_cache_ctrl (instance PROC_ID = 1) with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_snoop_cache_ctrl;
    import coh_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [3:0]  cpu_addr;
    logic [3:0]  cpu_wdata;
    logic        cpu_ready;
    logic [3:0]  cpu_rdata;
    logic        bus_req;
    logic        bus_grant;
    logic [1:0]  bus_cmd;
    logic [3:0]  bus_addr;
    logic        snp_valid;
    logic [1:0]  snp_cmd;
    logic [3:0]  snp_addr;
    logic [1:0]  snp_owner;
    logic [11:0] data_in;
    logic [11:0] supply_word;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    snoop_cache_ctrl #(
        .PROC_ID   (1),
        .NUM_LINES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ready   (cpu_ready),
        .cpu_rdata   (cpu_rdata),
        .bus_req     (bus_req),
        .bus_grant   (bus_grant),
        .bus_cmd     (bus_cmd),
        .bus_addr    (bus_addr),
        .snp_valid   (snp_valid),
        .snp_cmd     (snp_cmd),
        .snp_addr    (snp_addr),
        .snp_owner   (snp_owner),
        .data_in     (data_in),
        .supply_word (supply_word)
    );

    task automatic check(input string tag, input logic [11:0] observed, input logic [11:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%03h expected 0x%03h", tag, observed, expected);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cpu_ready"},   12'(cpu_ready),   12'h000);
        check({tag, "_cpu_rdata"},   12'(cpu_rdata),   12'h000);
        check({tag, "_bus_req"},     12'(bus_req),     12'h000);
        check({tag, "_bus_cmd"},     12'(bus_cmd),     12'h000);
        check({tag, "_bus_addr"},    12'(bus_addr),    12'h000);
        check({tag, "_supply_word"}, supply_word,      12'h000);
    endtask

    initial begin
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 4'h0;
        cpu_wdata = 4'h0;
        bus_grant = 1'b0;
        snp_valid = 1'b0;
        snp_cmd   = CMD_NONE;
        snp_addr  = 4'h0;
        snp_owner = 2'd0;
        data_in   = 12'h000;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Read miss on 0x5: request, grant, BusRd, fill from 0x13A.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h5;
        @(negedge clk);
        check("rd5_bus_req", 12'(bus_req), 12'h001);
        check("rd5_no_early_ready", 12'(cpu_ready), 12'h000);
        bus_grant = 1'b1;
        @(negedge clk);
        bus_grant = 1'b0;
        check("rd5_bus_cmd", 12'(bus_cmd), 12'(CMD_RD));
        check("rd5_bus_addr", 12'(bus_addr), 12'h005);
        check("rd5_req_dropped", 12'(bus_req), 12'h000);
        data_in = 12'h13A;
        @(negedge clk);
        check("rd5_resp_not_ready", 12'(cpu_ready), 12'h000);
        check("rd5_resp_cmd_none", 12'(bus_cmd), 12'h000);
        @(negedge clk);
        check("rd5_ready_3_after_grant", 12'(cpu_ready), 12'h001);
        check("rd5_rdata", 12'(cpu_rdata), 12'h00A);
        cpu_req = 1'b0; data_in = 12'h000;
        @(negedge clk);
        check("rd5_ready_one_pulse", 12'(cpu_ready), 12'h000);

        // Read hit on 0x5.
        cpu_req = 1'b1; cpu_addr = 4'h5;
        @(negedge clk);
        check("hit5_ready", 12'(cpu_ready), 12'h001);
        check("hit5_rdata", 12'(cpu_rdata), 12'h00A);
        check("hit5_no_bus_req", 12'(bus_req), 12'h000);
        cpu_req = 1'b0;
        @(negedge clk);

        // Write 0x5 = 0x7 while line is S: upgrade miss via BusRdX, data_in is ignored.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h5; cpu_wdata = 4'h7;
        @(negedge clk);
        check("wr5_bus_req", 12'(bus_req), 12'h001);
        bus_grant = 1'b1;
        @(negedge clk);
        bus_grant = 1'b0;
        check("wr5_bus_cmd", 12'(bus_cmd), 12'(CMD_RDX));
        check("wr5_bus_addr", 12'(bus_addr), 12'h005);
        data_in = 12'h13C;
        @(negedge clk);
        @(negedge clk);
        check("wr5_ready", 12'(cpu_ready), 12'h001);
        check("wr5_rdata", 12'(cpu_rdata), 12'h007);
        cpu_req = 1'b0; cpu_we = 1'b0; data_in = 12'h000;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 4'h5;
        @(negedge clk);
        check("rdM5_hit_ready", 12'(cpu_ready), 12'h001);
        check("rdM5_hit_rdata", 12'(cpu_rdata), 12'h007);
        cpu_req = 1'b0;
        @(negedge clk);

        // Snoop BusRd 0x5 from core 2: supply M/5/7 for one cycle, line drops to S.
        snp_valid = 1'b1; snp_cmd = CMD_RD; snp_addr = 4'h5; snp_owner = 2'd2;
        @(negedge clk);
        check("snp_rd_supply", supply_word, 12'h657);
        snp_valid = 1'b0;
        @(negedge clk);
        check("snp_rd_supply_one_cycle", supply_word, 12'h000);
        // Own BusRdX and a foreign BusWB must both be ignored.
        snp_valid = 1'b1; snp_cmd = CMD_RDX; snp_addr = 4'h5; snp_owner = 2'd1;
        @(negedge clk);
        check("snp_own_ignored", supply_word, 12'h000);
        snp_cmd = CMD_WB; snp_owner = 2'd2;
        @(negedge clk);
        check("snp_wb_ignored", supply_word, 12'h000);
        snp_valid = 1'b0;
        cpu_req = 1'b1; cpu_addr = 4'h5;
        @(negedge clk);
        check("snp_kept_line_ready", 12'(cpu_ready), 12'h001);
        check("snp_kept_line_rdata", 12'(cpu_rdata), 12'h007);
        cpu_req = 1'b0;
        @(negedge clk);

        // Line is S after the BusRd: write 0x5 = 0x7 must go to the bus again.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h5; cpu_wdata = 4'h7;
        @(negedge clk);
        check("wrS5_bus_req", 12'(bus_req), 12'h001);
        bus_grant = 1'b1;
        @(negedge clk);
        bus_grant = 1'b0;
        check("wrS5_bus_cmd", 12'(bus_cmd), 12'(CMD_RDX));
        @(negedge clk);
        @(negedge clk);
        check("wrS5_ready", 12'(cpu_ready), 12'h001);
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);

        // Read 0x9 evicts dirty 0x5: writeback, then BusRd 0x9 fill from 0x0B4.
        cpu_req = 1'b1; cpu_addr = 4'h9;
        @(negedge clk);
        check("rd9_wb_bus_req", 12'(bus_req), 12'h001);
        bus_grant = 1'b1;
        @(negedge clk);
        bus_grant = 1'b0;
        check("rd9_wb_cmd", 12'(bus_cmd), 12'(CMD_WB));
        check("rd9_wb_addr", 12'(bus_addr), 12'h005);
        check("rd9_wb_supply", supply_word, 12'hA57);
        check("rd9_wb_req_dropped", 12'(bus_req), 12'h000);
        @(negedge clk);
        check("rd9_req_again", 12'(bus_req), 12'h001);
        check("rd9_req_supply_clear", supply_word, 12'h000);
        bus_grant = 1'b1;
        @(negedge clk);
        bus_grant = 1'b0;
        check("rd9_bus_cmd", 12'(bus_cmd), 12'(CMD_RD));
        check("rd9_bus_addr", 12'(bus_addr), 12'h009);
        data_in = 12'h0B4;
        @(negedge clk);
        @(negedge clk);
        check("rd9_ready_5_after_grant", 12'(cpu_ready), 12'h001);
        check("rd9_rdata", 12'(cpu_rdata), 12'h004);
        cpu_req = 1'b0; data_in = 12'h000;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 4'h9;
        @(negedge clk);
        check("hit9_ready", 12'(cpu_ready), 12'h001);
        check("hit9_rdata", 12'(cpu_rdata), 12'h004);
        cpu_req = 1'b0;
        @(negedge clk);

        // Refill line 1 with S/0x5/0xE; the S victim 0x9 needs no writeback.
        cpu_req = 1'b1; cpu_addr = 4'h5;
        @(negedge clk);
        check("rd5b_bus_req", 12'(bus_req), 12'h001);
        bus_grant = 1'b1;
        @(negedge clk);
        bus_grant = 1'b0;
        check("rd5b_no_wb_cmd", 12'(bus_cmd), 12'(CMD_RD));
        data_in = 12'h00E;
        @(negedge clk);
        @(negedge clk);
        check("rd5b_rdata", 12'(cpu_rdata), 12'h00E);
        cpu_req = 1'b0; data_in = 12'h000;
        @(negedge clk);

        // Same-cycle CPU read 0x5 and BusRdX 0x5 from core 0: snoop wins, CPU misses.
        cpu_req = 1'b1; cpu_addr = 4'h5;
        snp_valid = 1'b1; snp_cmd = CMD_RDX; snp_addr = 4'h5; snp_owner = 2'd0;
        @(negedge clk);
        snp_valid = 1'b0;
        check("race_miss_bus_req", 12'(bus_req), 12'h001);
        check("race_no_ready", 12'(cpu_ready), 12'h000);
        check("race_supply", supply_word, 12'h55E);
        bus_grant = 1'b1;
        @(negedge clk);
        bus_grant = 1'b0;
        check("race_bus_cmd", 12'(bus_cmd), 12'(CMD_RD));
        check("race_supply_one_cycle", supply_word, 12'h000);
        data_in = 12'h003;
        @(negedge clk);
        @(negedge clk);
        check("race_rdata", 12'(cpu_rdata), 12'h003);
        cpu_req = 1'b0; data_in = 12'h000;
        @(negedge clk);

        // Reset during REQ aborts the miss and clears all lines.
        cpu_req = 1'b1; cpu_addr = 4'hC;
        @(negedge clk);
        check("rstreq_bus_req", 12'(bus_req), 12'h001);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("rst_in_req");
        rst = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check_outputs_zero("after_rst_idle");
        cpu_req = 1'b1; cpu_addr = 4'h5;
        @(negedge clk);
        check("after_rst_line_invalid", 12'(bus_req), 12'h001);
        check("after_rst_no_ready", 12'(cpu_ready), 12'h000);
        cpu_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
